// File: rtl/pulse_sync_scheduler.sv
// rtl/pulse_sync_scheduler.sv - round-robin scheduler feeding one shared pulse CDC channel
// Latches requests, issues one pulse per grant, then holds off for the channel round trip.
module pulse_sync_scheduler #(
    parameter int P_REQ_NUM   = 4,
    parameter int P_ID_W      = 2,
    parameter int P_GUARD_CYC = 8
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic [P_REQ_NUM-1:0] i_req,
    input  logic                 i_clr_ovf,
    output logic                 o_sync_pulse,
    output logic [P_ID_W-1:0]    o_sync_id,
    output logic                 o_busy,
    output logic [P_REQ_NUM-1:0] o_pending,
    output logic                 o_ovf,
    output logic [P_ID_W-1:0]    o_ovf_id,
    output logic [7:0]           o_ovf_cnt
);

    localparam int CNT_W = $clog2(P_GUARD_CYC + 1);
    localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'(P_GUARD_CYC - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_GUARD = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [P_ID_W-1:0]    last_q, last_d;
    logic [P_ID_W-1:0]    sync_id_q, sync_id_d;
    logic                 sync_pulse_q, sync_pulse_d;
    logic                 busy_q, busy_d;
    logic [P_REQ_NUM-1:0] pending_q, pending_d;
    logic                 ovf_q, ovf_d;
    logic [P_ID_W-1:0]    ovf_id_q, ovf_id_d;
    logic [7:0]           ovf_cnt_q, ovf_cnt_d;
    logic [CNT_W-1:0]     guard_q, guard_d;

    logic [2*P_REQ_NUM-1:0] pend2;
    logic [P_REQ_NUM-1:0]   rot;
    logic                   grant_found;
    logic [P_ID_W-1:0]      grant_idx;
    int                     grant_sum;
    logic [P_REQ_NUM-1:0]   clr_mask;
    logic [P_REQ_NUM-1:0]   ovf_vec;

    // Rotate pending so bit 0 is the requester right after the last one served.
    always_comb begin
        pend2       = {pending_q, pending_q};
        rot         = P_REQ_NUM'(pend2 >> (int'(last_q) + 1));
        grant_found = 1'b0;
        grant_idx   = '0;
        grant_sum   = 0;
        for (int j = 0; j < P_REQ_NUM; j++) begin
            if (!grant_found && rot[j]) begin
                grant_found = 1'b1;
                grant_sum   = int'(last_q) + 1 + j;
                if (grant_sum >= P_REQ_NUM) begin
                    grant_sum = grant_sum - P_REQ_NUM;
                end
                grant_idx = P_ID_W'(grant_sum);
            end
        end
    end

    always_comb begin
        clr_mask = '0;
        for (int k = 0; k < P_REQ_NUM; k++) begin
            clr_mask[k] = (state_q == S_ISSUE) && (sync_id_q == P_ID_W'(k));
        end
        // A request landing on its own clear edge survives and is not an overflow.
        ovf_vec   = i_req & pending_q & ~clr_mask;
        pending_d = (pending_q & ~clr_mask) | i_req;
        ovf_d     = |ovf_vec;
        ovf_id_d  = '0;
        for (int k = P_REQ_NUM - 1; k >= 0; k--) begin
            if (ovf_vec[k]) begin
                ovf_id_d = P_ID_W'(k);
            end
        end
        ovf_cnt_d = ovf_cnt_q;
        if (ovf_d) begin
            if (i_clr_ovf) begin
                ovf_cnt_d = 8'd1;
            end else if (ovf_cnt_q != 8'hFF) begin
                ovf_cnt_d = ovf_cnt_q + 8'd1;
            end
        end else if (i_clr_ovf) begin
            ovf_cnt_d = 8'd0;
        end
    end

    always_comb begin
        state_d      = state_q;
        last_d       = last_q;
        sync_id_d    = sync_id_q;
        sync_pulse_d = 1'b0;
        busy_d       = busy_q;
        guard_d      = guard_q;
        case (state_q)
            S_IDLE: begin
                busy_d = 1'b0;
                if (grant_found) begin
                    last_d       = grant_idx;
                    sync_id_d    = grant_idx;
                    sync_pulse_d = 1'b1;
                    busy_d       = 1'b1;
                    state_d      = S_ISSUE;
                end
            end
            S_ISSUE: begin
                guard_d = '0;
                busy_d  = 1'b1;
                state_d = S_GUARD;
            end
            S_GUARD: begin
                if (guard_q == GUARD_LAST) begin
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end else begin
                    guard_d = guard_q + CNT_W'(1);
                end
            end
            default: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q      <= S_IDLE;
            last_q       <= P_ID_W'(P_REQ_NUM - 1);
            sync_id_q    <= '0;
            sync_pulse_q <= 1'b0;
            busy_q       <= 1'b0;
            pending_q    <= '0;
            ovf_q        <= 1'b0;
            ovf_id_q     <= '0;
            ovf_cnt_q    <= 8'd0;
            guard_q      <= '0;
        end else begin
            state_q      <= state_d;
            last_q       <= last_d;
            sync_id_q    <= sync_id_d;
            sync_pulse_q <= sync_pulse_d;
            busy_q       <= busy_d;
            pending_q    <= pending_d;
            ovf_q        <= ovf_d;
            ovf_id_q     <= ovf_id_d;
            ovf_cnt_q    <= ovf_cnt_d;
            guard_q      <= guard_d;
        end
    end

    assign o_sync_pulse = sync_pulse_q;
    assign o_sync_id    = sync_id_q;
    assign o_busy       = busy_q;
    assign o_pending    = pending_q;
    assign o_ovf        = ovf_q;
    assign o_ovf_id     = ovf_id_q;
    assign o_ovf_cnt    = ovf_cnt_q;

endmodule

// File: tb/tb_pulse_sync_scheduler.sv
// tb/tb_pulse_sync_scheduler.sv - directed self-checking bench for pulse_sync_scheduler
module tb_pulse_sync_scheduler;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [3:0] req = 4'b0;
    logic       clr = 1'b0;
    logic       o_sync_pulse;
    logic [1:0] o_sync_id;
    logic       o_busy;
    logic [3:0] o_pending;
    logic       o_ovf;
    logic [1:0] o_ovf_id;
    logic [7:0] o_ovf_cnt;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int ovf_seen = 0;

    pulse_sync_scheduler #(.P_REQ_NUM(4), .P_ID_W(2), .P_GUARD_CYC(8)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_req(req), .i_clr_ovf(clr),
        .o_sync_pulse(o_sync_pulse), .o_sync_id(o_sync_id), .o_busy(o_busy),
        .o_pending(o_pending), .o_ovf(o_ovf), .o_ovf_id(o_ovf_id), .o_ovf_cnt(o_ovf_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (o_ovf) ovf_seen <= ovf_seen + 1;

    typedef struct {
        logic [3:0] req;
        logic       clr;
        logic       pulse;
        logic [1:0] id;
        logic       busy;
        logic [3:0] pend;
        logic       ovf;
        logic [1:0] ovf_id;
        logic [7:0] cnt;
    } vec_t;

    vec_t tbl[16];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req   = 4'b0;
        clr   = 1'b0;
        repeat (3) step();
        rst_n = 1'b1;
    endtask

    task automatic wait_pulse(input int max_cyc, output logic got, output logic [1:0] id, output int t);
        got = 1'b0;
        id  = 2'd0;
        t   = 0;
        for (int n = 0; n < max_cyc && !got; n++) begin
            step();
            if (o_sync_pulse) begin
                got = 1'b1;
                id  = o_sync_id;
                t   = cyc;
            end
        end
    endtask

    // Make sure every bit of mask is pending and the next edge is not an ISSUE edge.
    task automatic prepare(input logic [3:0] mask);
        for (int n = 0; n < 30; n++) begin
            if (((o_pending & mask) == mask) && !o_sync_pulse) break;
            req = mask;
            step();
            req = 4'b0;
        end
    endtask

    function automatic vec_t mk(input logic [3:0] r, input logic c, input logic p, input logic [1:0] i,
                                input logic b, input logic [3:0] pe, input logic o, input logic [1:0] oi,
                                input logic [7:0] cn);
        vec_t v;
        v.req = r; v.clr = c; v.pulse = p; v.id = i; v.busy = b;
        v.pend = pe; v.ovf = o; v.ovf_id = oi; v.cnt = cn;
        return v;
    endfunction

    initial begin
        logic       got;
        logic [1:0] id;
        logic [1:0] prev_id;
        int         t;
        int         t_prev;
        int         ov0;
        int         npulse;

        tbl[0]  = mk(4'b0100, 0, 0, 2'd0, 0, 4'b0100, 0, 2'd0, 8'd0);
        tbl[1]  = mk(4'b0000, 0, 1, 2'd2, 1, 4'b0100, 0, 2'd0, 8'd0);
        tbl[2]  = mk(4'b0000, 0, 0, 2'd2, 1, 4'b0000, 0, 2'd0, 8'd0);
        for (int i = 3; i <= 9; i++) tbl[i] = mk(4'b0000, 0, 0, 2'd2, 1, 4'b0000, 0, 2'd0, 8'd0);
        tbl[10] = mk(4'b0000, 0, 0, 2'd2, 0, 4'b0000, 0, 2'd0, 8'd0);
        tbl[11] = mk(4'b1000, 0, 0, 2'd2, 0, 4'b1000, 0, 2'd0, 8'd0);
        tbl[12] = mk(4'b1000, 0, 1, 2'd3, 1, 4'b1000, 1, 2'd3, 8'd1);
        tbl[13] = mk(4'b1000, 0, 0, 2'd3, 1, 4'b1000, 0, 2'd0, 8'd1);
        tbl[14] = mk(4'b0000, 0, 0, 2'd3, 1, 4'b1000, 0, 2'd0, 8'd1);
        tbl[15] = mk(4'b0000, 1, 0, 2'd3, 1, 4'b1000, 0, 2'd0, 8'd0);

        // Reset state
        rst_n = 1'b0;
        step();
        step();
        chk("reset_outputs", {16'd0, o_sync_pulse, o_sync_id, o_busy, o_pending, o_ovf, o_ovf_id, o_ovf_cnt}, 32'd0);
        rst_n = 1'b1;

        // Table: single request, then overflow, collision and clear
        t_prev = 0;
        for (int i = 0; i < 16; i++) begin
            req = tbl[i].req;
            clr = tbl[i].clr;
            step();
            chk($sformatf("vec%0d_pulse", i), o_sync_pulse, tbl[i].pulse);
            chk($sformatf("vec%0d_id", i), o_sync_id, tbl[i].id);
            chk($sformatf("vec%0d_busy", i), o_busy, tbl[i].busy);
            chk($sformatf("vec%0d_pending", i), o_pending, tbl[i].pend);
            chk($sformatf("vec%0d_ovf", i), o_ovf, tbl[i].ovf);
            chk($sformatf("vec%0d_ovf_id", i), o_ovf_id, tbl[i].ovf_id);
            chk($sformatf("vec%0d_cnt", i), o_ovf_cnt, tbl[i].cnt);
            if (i == 12) t_prev = cyc;
        end
        req = 4'b0;
        clr = 1'b0;
        wait_pulse(20, got, id, t);
        chk("drain_got", got, 1);
        chk("drain_id", id, 3);
        chk("drain_spacing", t - t_prev, 10);

        // Simultaneous requests
        do_reset();
        ov0 = ovf_seen;
        req = 4'b1111;
        step();
        req = 4'b0;
        t_prev = 0;
        for (int i = 0; i < 4; i++) begin
            wait_pulse(30, got, id, t);
            chk($sformatf("all_got%0d", i), got, 1);
            chk($sformatf("all_id%0d", i), id, i);
            if (i > 0) chk($sformatf("all_spacing%0d", i), t - t_prev, 10);
            t_prev = t;
        end
        repeat (12) step();
        chk("all_busy_done", o_busy, 0);
        chk("all_no_ovf", ovf_seen - ov0, 0);

        // Round-robin fairness
        do_reset();
        req = 4'b0010;
        step();
        req = 4'b0;
        wait_pulse(10, got, id, t);
        chk("rr_first", id, 1);
        step();
        req = 4'b0011;
        step();
        req = 4'b0;
        prev_id = 2'd1;
        for (int n = 0; n < 6; n++) begin
            wait_pulse(30, got, id, t);
            chk($sformatf("rr_got%0d", n), got, 1);
            chk($sformatf("rr_id%0d", n), id, n % 2);
            chk($sformatf("rr_alt%0d", n), (id != prev_id), 1);
            prev_id = id;
            step();
            req = 4'b0011;
            step();
            req = 4'b0;
        end

        // Overflow saturation, multi-overflow lowest id, clear with overflow
        do_reset();
        req = 4'b1000;
        repeat (300) step();
        req = 4'b0;
        chk("sat_cnt", o_ovf_cnt, 255);
        prepare(4'b1100);
        req = 4'b1100;
        step();
        req = 4'b0;
        chk("multi_ovf", o_ovf, 1);
        chk("multi_ovf_id", o_ovf_id, 2);
        chk("multi_sat_cnt", o_ovf_cnt, 255);
        prepare(4'b1000);
        req = 4'b1000;
        clr = 1'b1;
        step();
        req = 4'b0;
        clr = 1'b0;
        chk("clr_ovf_flag", o_ovf, 1);
        chk("clr_ovf_id", o_ovf_id, 3);
        chk("clr_ovf_cnt", o_ovf_cnt, 1);
        clr = 1'b1;
        step();
        clr = 1'b0;
        chk("clr_alone_cnt", o_ovf_cnt, 0);
        chk("clr_alone_ovf", o_ovf, 0);

        // Set/clear collision on requester 0
        do_reset();
        req = 4'b0001;
        step();
        req = 4'b0;
        step();
        chk("col_pulse", o_sync_pulse, 1);
        chk("col_id", o_sync_id, 0);
        t_prev = cyc;
        req = 4'b0001;
        step();
        req = 4'b0;
        chk("col_pending", o_pending[0], 1);
        chk("col_no_ovf", o_ovf, 0);
        chk("col_busy", o_busy, 1);
        wait_pulse(30, got, id, t);
        chk("col_got", got, 1);
        chk("col_id2", id, 0);
        chk("col_spacing", t - t_prev, 10);

        // Reset mid-GUARD with requests pending
        do_reset();
        req = 4'b0001;
        step();
        req = 4'b0;
        step();
        step();
        req = 4'b0110;
        step();
        req = 4'b0;
        step();
        step();
        chk("mid_pending", o_pending, 4'b0110);
        chk("mid_busy", o_busy, 1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_outputs", {16'd0, o_sync_pulse, o_sync_id, o_busy, o_pending, o_ovf, o_ovf_id, o_ovf_cnt}, 32'd0);
        repeat (3) step();
        rst_n = 1'b1;
        npulse = 0;
        for (int n = 0; n < 30; n++) begin
            step();
            if (o_sync_pulse) npulse++;
        end
        chk("mid_no_pulse", npulse, 0);
        chk("mid_pending_after", o_pending, 0);
        req = 4'b0100;
        step();
        req = 4'b0;
        wait_pulse(10, got, id, t);
        chk("mid_new_got", got, 1);
        chk("mid_new_id", id, 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
